// File: rtl/keypad_lock_ctrl.sv
// Passcode lock controller: edge-detects one-hot keypad presses into a BCD
// entry buffer, then programs or verifies a stored passcode on enter.
// Wrong verifies are counted and trigger a timed lockout, while a correct
// verify opens a timed unlock window in which the code may be reprogrammed.
module keypad_lock_ctrl #(
   parameter int DIGITS      = 8,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1024,
   parameter int UNLOCK_CYC  = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [9:0]                   key,
   input  logic                         enter,
   input  logic                         clr,
   input  logic                         set_mode,
   output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
   output logic                         unlock,
   output logic                         fail,
   output logic                         lockout,
   output logic                         code_set,
   output logic [3:0]                   fail_cnt
);

   localparam int CW   = $clog2(DIGITS + 1);
   localparam int BW   = DIGITS * 4;
   localparam int TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
   localparam int TW   = $clog2(TMAX);

   // State bits double as the unlock/lockout outputs, so both are register outputs.
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_OPEN = 2'b01;
   localparam logic [1:0] S_LOCK = 2'b10;

   localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYC - 1);
   localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYC - 1);
   localparam logic [CW-1:0] FULL     = CW'(DIGITS);
   localparam logic [3:0]    FAIL_LIM = 4'(MAX_FAIL);

   logic [1:0]    state_q, state_d;
   logic [9:0]    key_prev_q;
   logic [BW-1:0] entry_q, entry_d;
   logic [BW-1:0] code_q, code_d;
   logic          code_set_q, code_set_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          fail_q, fail_d;
   logic [3:0]    fail_cnt_q, fail_cnt_d;

   logic          press;
   logic [3:0]    digit;
   logic          full;
   logic          match;
   logic [3:0]    fail_next;

   // Press = exactly one key down after a cycle with no keys down; digit = its index.
   always_comb begin
      press = (key != 10'd0) && ((key & (key - 10'd1)) == 10'd0) && (key_prev_q == 10'd0);
      digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (key[i]) digit = 4'(i);
      end
   end

   assign full      = (cnt_q == FULL);
   assign match     = code_set_q && full && (entry_q == code_q);
   assign fail_next = fail_cnt_q + 4'd1;

   // Next-state: clr beats enter beats press; the timers run in OPEN and LOCK.
   always_comb begin
      state_d    = state_q;
      entry_d    = entry_q;
      cnt_d      = cnt_q;
      code_d     = code_q;
      code_set_d = code_set_q;
      timer_d    = timer_q;
      fail_cnt_d = fail_cnt_q;
      fail_d     = 1'b0;
      if (state_q == S_LOCK) begin
         entry_d = '0;
         cnt_d   = '0;
         if (timer_q == '0) begin
            state_d    = S_IDLE;
            fail_cnt_d = '0;
         end else begin
            timer_d = timer_q - 1'b1;
         end
      end else begin
         if (clr) begin
            entry_d = '0;
            cnt_d   = '0;
         end else if (enter) begin
            entry_d = '0;
            cnt_d   = '0;
            if (state_q == S_IDLE) begin
               if (set_mode) begin
                  // First-time programming only; later changes need OPEN.
                  if (!code_set_q && full) begin
                     code_d     = entry_q;
                     code_set_d = 1'b1;
                  end else begin
                     fail_d = 1'b1;
                  end
               end else if (match) begin
                  state_d    = S_OPEN;
                  fail_cnt_d = '0;
                  timer_d    = T_UNLOCK;
               end else begin
                  fail_d     = 1'b1;
                  fail_cnt_d = fail_next;
                  if (fail_next == FAIL_LIM) begin
                     state_d = S_LOCK;
                     timer_d = T_LOCK;
                  end
               end
            end else begin
               if (set_mode) begin
                  if (full) begin
                     code_d  = entry_q;
                     state_d = S_IDLE;
                  end else begin
                     fail_d = 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
         end else if (press && !full) begin
            entry_d = (entry_q << 4) | BW'(digit);
            cnt_d   = cnt_q + 1'b1;
         end
         // The unlock window expires even if this cycle also saw entry activity.
         if (state_q == S_OPEN && state_d == S_OPEN) begin
            if (timer_q == '0) begin
               state_d = S_IDLE;
               entry_d = '0;
               cnt_d   = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
      end
   end

   // All state, including the stored code, is cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         key_prev_q <= '0;
         entry_q    <= '0;
         code_q     <= '0;
         code_set_q <= 1'b0;
         cnt_q      <= '0;
         timer_q    <= '0;
         fail_q     <= 1'b0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         key_prev_q <= key;
         entry_q    <= entry_d;
         code_q     <= code_d;
         code_set_q <= code_set_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         fail_q     <= fail_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign digit_cnt = cnt_q;
   assign unlock    = state_q[0];
   assign lockout   = state_q[1];
   assign fail      = fail_q;
   assign code_set  = code_set_q;
   assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random keypad traffic,
// compared every cycle against a digit-queue reference model.
module tb_keypad_lock_ctrl;

   localparam int DIGITS      = 8;
   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT_CYC = 1024;
   localparam int UNLOCK_CYC  = 256;
   localparam int M_IDLE = 0, M_OPEN = 1, M_LOCK = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [9:0] key;
   logic       enter, clr, set_mode;
   logic [3:0] digit_cnt;
   logic       unlock, fail, lockout, code_set;
   logic [3:0] fail_cnt;

   logic [9:0] key2;
   logic       enter2, clr2, set2;
   logic [2:0] digit_cnt2;
   logic       unlock2, fail2, lockout2, code_set2;
   logic [3:0] fail_cnt2;

   keypad_lock_ctrl #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL),
                      .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(UNLOCK_CYC)) u_dut (
      .clk(clk), .rst(rst), .key(key), .enter(enter), .clr(clr), .set_mode(set_mode),
      .digit_cnt(digit_cnt), .unlock(unlock), .fail(fail), .lockout(lockout),
      .code_set(code_set), .fail_cnt(fail_cnt));

   keypad_lock_ctrl #(.DIGITS(4), .MAX_FAIL(1), .LOCKOUT_CYC(8), .UNLOCK_CYC(4)) u_dut_small (
      .clk(clk), .rst(rst), .key(key2), .enter(enter2), .clr(clr2), .set_mode(set2),
      .digit_cnt(digit_cnt2), .unlock(unlock2), .fail(fail2), .lockout(lockout2),
      .code_set(code_set2), .fail_cnt(fail_cnt2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: entry buffer and stored code as digit queues.
   int         m_buf[$];
   int         m_code[$];
   bit         m_cset;
   int         m_mode;
   int         m_left;
   bit         m_fail;
   int         m_fcnt;
   logic [9:0] m_prev;

   task automatic model_reset();
      m_buf.delete();
      m_code.delete();
      m_cset = 0; m_mode = M_IDLE; m_left = 0; m_fail = 0; m_fcnt = 0; m_prev = '0;
   endtask

   function automatic bit code_matches();
      if (m_buf.size() != m_code.size()) return 0;
      foreach (m_buf[i]) if (m_buf[i] != m_code[i]) return 0;
      return 1;
   endfunction

   task automatic model_step(input logic [9:0] k, input bit e, input bit c, input bit s);
      bit pr, full, was_open;
      int d;
      pr = ($countones(k) == 1) && (m_prev == 10'd0);
      d = 0;
      for (int i = 0; i < 10; i++) if (k[i]) d = i;
      m_prev = k;
      m_fail = 0;
      if (m_mode == M_LOCK) begin
         m_left--;
         if (m_left == 0) begin m_mode = M_IDLE; m_fcnt = 0; end
         return;
      end
      was_open = (m_mode == M_OPEN);
      full = (m_buf.size() == DIGITS);
      if (c) m_buf.delete();
      else if (e) begin
         if (m_mode == M_IDLE) begin
            if (s) begin
               if (!m_cset && full) begin m_code = m_buf; m_cset = 1; end
               else m_fail = 1;
            end else if (m_cset && full && code_matches()) begin
               m_mode = M_OPEN; m_fcnt = 0; m_left = UNLOCK_CYC;
            end else begin
               m_fail = 1; m_fcnt++;
               if (m_fcnt == MAX_FAIL) begin m_mode = M_LOCK; m_left = LOCKOUT_CYC; end
            end
         end else begin
            if (s) begin
               if (full) begin m_code = m_buf; m_mode = M_IDLE; end
               else m_fail = 1;
            end else m_mode = M_IDLE;
         end
         m_buf.delete();
      end else if (pr && m_buf.size() < DIGITS) m_buf.push_back(d);
      if (was_open && m_mode == M_OPEN) begin
         m_left--;
         if (m_left == 0) begin m_mode = M_IDLE; m_buf.delete(); end
      end
   endtask

   task automatic compare_all();
      chk("digit_cnt", digit_cnt, m_buf.size());
      chk("unlock", unlock, m_mode == M_OPEN);
      chk("lockout", lockout, m_mode == M_LOCK);
      chk("fail", fail, m_fail);
      chk("code_set", code_set, m_cset);
      chk("fail_cnt", fail_cnt, m_fcnt);
   endtask

   // One clock of stimulus on the main DUT, then compare at the next falling edge.
   task automatic step(input logic [9:0] k, input bit e, input bit c, input bit s);
      key = k; enter = e; clr = c; set_mode = s;
      model_step(k, e, c, s);
      @(negedge clk);
      compare_all();
   endtask

   task automatic press(input int d, input bit s);
      step(10'(1 << d), 0, 0, s);
      step(10'd0, 0, 0, s);
   endtask

   task automatic type_seq(input int q[$], input bit s);
      foreach (q[i]) press(q[i], s);
   endtask

   task automatic step2(input logic [9:0] k, input bit e, input bit s);
      key2 = k; enter2 = e; clr2 = 1'b0; set2 = s;
      @(negedge clk);
   endtask

   task automatic press2(input int d, input bit s);
      step2(10'(1 << d), 0, s);
      step2(10'd0, 0, s);
   endtask

   int CODE_A[$] = '{2, 1, 9, 3, 5, 4, 8, 8};
   int CODE_B[$] = '{2, 1, 9, 3, 5, 4, 8, 7};
   int CODE_C[$] = '{1, 2, 3, 4, 5, 6, 7, 8};

   initial begin
      int n;
      int r;
      int q[$];
      rst = 1'b0;
      key = '0; enter = 0; clr = 0; set_mode = 0;
      key2 = '0; enter2 = 0; clr2 = 0; set2 = 0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      chk("rst_small_cnt", digit_cnt2, 0);
      chk("rst_small_code_set", code_set2, 0);
      rst = 1'b1;
      step(10'd0, 0, 0, 0);

      // Small instance: one wrong 4-digit code locks out for 8 cycles.
      press2(1, 1); press2(2, 1); press2(3, 1); press2(4, 1);
      chk("small_cnt_full", digit_cnt2, 4);
      step2(10'd0, 1, 1);
      chk("small_code_set", code_set2, 1);
      press2(1, 0); press2(2, 0); press2(3, 0); press2(5, 0);
      step2(10'd0, 1, 0);
      chk("small_lockout", lockout2, 1);
      chk("small_fail", fail2, 1);
      chk("small_fail_cnt", fail_cnt2, 1);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         step2(10'd0, 0, 0);
         if (lockout2) n++;
      end
      chk("small_lock_len", n, 8);
      chk("small_fail_cnt_after", fail_cnt2, 0);
      press2(1, 0); press2(2, 0); press2(3, 0); press2(4, 0);
      step2(10'd0, 1, 0);
      n = unlock2 ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         step2(10'd0, 0, 0);
         if (unlock2) n++;
      end
      chk("small_open_len", n, 4);

      // Program and verify.
      type_seq(CODE_A, 1);
      step(10'd0, 1, 0, 1);
      chk("prog_code_set", code_set, 1);
      chk("prog_cnt", digit_cnt, 0);
      chk("prog_fail", fail, 0);
      type_seq(CODE_A, 0);
      step(10'd0, 1, 0, 0);
      n = unlock ? 1 : 0;
      for (int i = 0; i < 299; i++) begin
         step(10'd0, 0, 0, 0);
         if (unlock) n++;
      end
      chk("open_len", n, 256);
      chk("open_fail_cnt", fail_cnt, 0);

      // Three wrong codes lock out; keys are ignored while locked.
      for (int a = 1; a <= 3; a++) begin
         type_seq(CODE_B, 0);
         step(10'd0, 1, 0, 0);
         chk("wrong_fail", fail, 1);
         chk("wrong_fail_cnt", fail_cnt, a);
      end
      chk("lock_on", lockout, 1);
      n = 1;
      for (int i = 0; i < 1100; i++) begin
         if (m_mode == M_LOCK && (i % 4) == 0) step(10'(1 << (i % 10)), 0, 0, 0);
         else step(10'd0, 0, 0, 0);
         if (lockout) n++;
      end
      chk("lock_len", n, 1024);
      chk("lock_fail_cnt_after", fail_cnt, 0);
      chk("lock_cnt_after", digit_cnt, 0);
      type_seq(CODE_A, 0);
      step(10'd0, 1, 0, 0);
      chk("post_lock_unlock", unlock, 1);
      step(10'd0, 1, 0, 0);
      chk("relock", unlock, 0);
      step(10'd0, 0, 0, 0);

      // Press-detect edge cases.
      step(10'b0000000101, 0, 0, 0);
      step(10'b0000000101, 0, 0, 0);
      step(10'd0, 0, 0, 0);
      chk("multi_hot", digit_cnt, 0);
      for (int i = 0; i < 10; i++) step(10'd32, 0, 0, 0);
      step(10'd0, 0, 0, 0);
      chk("hold_key", digit_cnt, 1);
      step(10'd0, 0, 1, 0);
      type_seq(CODE_A, 0);
      press(7, 0);
      chk("ninth_press", digit_cnt, 8);
      step(10'd0, 1, 0, 0);
      chk("ninth_buf_kept", unlock, 1);
      step(10'd0, 1, 0, 0);
      step(10'd0, 0, 0, 0);
      press(3, 0);
      step(10'd16, 0, 1, 0);
      step(10'd0, 0, 0, 0);
      chk("clr_press", digit_cnt, 0);

      // Reprogram inside the unlock window.
      type_seq(CODE_A, 0);
      step(10'd0, 1, 0, 0);
      type_seq(CODE_C, 1);
      step(10'd0, 1, 0, 1);
      chk("reprog_idle", unlock, 0);
      type_seq(CODE_A, 0);
      step(10'd0, 1, 0, 0);
      chk("old_code_fails", fail, 1);
      type_seq(CODE_C, 0);
      step(10'd0, 1, 0, 0);
      chk("new_code_opens", unlock, 1);
      step(10'd0, 1, 0, 0);
      type_seq(CODE_A, 1);
      step(10'd0, 1, 0, 1);
      chk("set_when_set_fails", fail, 1);
      type_seq(CODE_C, 0);
      step(10'd0, 1, 0, 0);
      chk("code_unchanged", unlock, 1);

      // Asynchronous reset in the middle of OPEN.
      step(10'd0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_unlock", unlock, 0);
      chk("arst_code_set", code_set, 0);
      chk("arst_fail_cnt", fail_cnt, 0);
      model_reset();
      @(negedge clk);
      compare_all();
      rst = 1'b1;
      step(10'd0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < DIGITS; i++) q.push_back($urandom_range(0, 9));
      type_seq(q, 1);
      step(10'd0, 1, 0, 1);
      for (int it = 0; it < 2500; it++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) step(10'(1 << $urandom_range(0, 9)), 0, 0, $urandom_range(0, 1));
            step(10'd0, 0, 0, 0);
         end else if (r < 50) begin
            step(10'($urandom_range(1, 1023)), 0, 0, 0);
            step(10'd0, 0, 0, 0);
         end else if (r < 60) begin
            n = ($urandom_range(0, 9) == 0) ? 2 : 1;
            r = $urandom_range(0, 1);
            for (int j = 0; j < n; j++) step(10'd0, 1, 0, r[0]);
         end else if (r < 65) begin
            step(($urandom_range(0, 1) != 0) ? 10'(1 << $urandom_range(0, 9)) : 10'd0,
                 $urandom_range(0, 1), 1, 0);
            step(10'd0, 0, 0, 0);
         end else if (r < 80) begin
            r = $urandom_range(0, 3);
            type_seq(m_code, 0);
            step(10'd0, 1, 0, r == 0);
         end else begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) step(10'd0, 0, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
